// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side upsizer.
// Flush FSM state encoding.
package fifo_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH_WAIT,
        S_FLUSH_EMIT
    } upsizer_state_t;

endpackage

// File: rtl/fifo_rd_upsizer.sv
// Pops narrow FIFO words and packs RATIO of them into one wide beat.
// flush pushes out a partial beat with a keep mask.
module fifo_rd_upsizer
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst_sync_n,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [WIDTH-1:0]         fifo_dout,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep
);

    localparam int CW = $clog2(RATIO + 1);
    localparam int IW = $clog2(RATIO);
    localparam logic [CW-1:0] FULL = CW'(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    upsizer_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           pend;
    logic [WIDTH-1:0] slot [RATIO];

    logic out_free;
    logic land_last;
    logic load_full;
    logic load_part;
    logic pop;
    logic done_nxt;
    logic [WIDTH*RATIO-1:0] full_beat;
    logic [WIDTH*RATIO-1:0] part_beat;
    logic [RATIO-1:0]       part_keep;

    assign out_free  = !out_valid || out_ready;
    assign land_last = pend && (cnt == LAST);
    assign load_full = out_free && (land_last || cnt == FULL);
    assign load_part = out_free && (state == S_FLUSH_EMIT);

    // A completing word that drains straight out frees its slot, so the
    // next pop may overlap it and keep one beat per RATIO cycles.
    assign fifo_rd_en = rst_sync_n && (state == S_RUN) && !fifo_empty &&
                        ((cnt + CW'(pend) < FULL) || (land_last && out_free));
    assign pop = fifo_rd_en && !fifo_empty;

    always_comb begin
        full_beat = '0;
        part_beat = '0;
        part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            full_beat[i*WIDTH +: WIDTH] = slot[i];
            if (CW'(i) < cnt) begin
                part_beat[i*WIDTH +: WIDTH] = slot[i];
                part_keep[i] = 1'b1;
            end
        end
        if (land_last) begin
            full_beat[(RATIO-1)*WIDTH +: WIDTH] = fifo_dout;
        end
    end

    // Pack register
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            pend <= pop;
            if (load_full || load_part) begin
                cnt <= '0;
            end else if (pend) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend && !(land_last && out_free)) begin
            slot[cnt[IW-1:0]] <= fifo_dout;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (load_full) begin
            out_valid <= 1'b1;
            out_data  <= full_beat;
            out_keep  <= '1;
        end else if (load_part) begin
            out_valid <= 1'b1;
            out_data  <= part_beat;
            out_keep  <= part_keep;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flush FSM
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            state      <= S_RUN;
            flush_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= done_nxt;
            busy       <= (state_nxt != S_RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_FLUSH_WAIT;
                end
            end
            S_FLUSH_WAIT: begin
                if (!pend && cnt != FULL) begin
                    if (cnt == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_FLUSH_EMIT;
                    end
                end
            end
            S_FLUSH_EMIT: begin
                if (out_free) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Randomised bench for fifo_rd_upsizer against a queue-based model
// that groups popped words into beats and cuts partials on flush.
module tb_fifo_rd_upsizer;

    localparam int W = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_sync_n = 1'b0;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic [W-1:0]   fifo_dout = '0;
    logic           flush = 1'b0;
    logic           flush_done;
    logic           busy;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W*R-1:0] out_data;
    logic [R-1:0]   out_keep;

    always #5 clk = ~clk;

    fifo_rd_upsizer #(.WIDTH(W), .RATIO(R)) dut (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep)
    );

    typedef struct {
        logic [W*R-1:0] d;
        logic [R-1:0]   k;
    } beat_t;

    logic [W-1:0] fq[$];
    logic [W-1:0] acc[$];
    beat_t        exp_q[$];
    beat_t        got_q[$];

    int  total = 0;
    int  passed = 0;
    bit  mbusy = 0;
    int  exp_done = 0;
    bit  done_seen = 0;
    int  done_fsz = 0;
    bit  hold = 0;
    logic [W*R-1:0] hold_d;
    logic [R-1:0]   hold_k;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic chk_eq(input string nm,
                          input logic [63:0] act, input logic [63:0] expv);
        chk(act === expv, nm, act, expv);
    endtask

    function automatic beat_t pack_acc();
        beat_t b;
        b.d = '0;
        b.k = '0;
        for (int i = 0; i < acc.size(); i++) begin
            b.d[i*W +: W] = acc[i];
            b.k[i] = 1'b1;
        end
        return b;
    endfunction

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic cycle();
        bit    popping;
        beat_t e;
        popping = 0;
        @(negedge clk);
        if (rst_sync_n) begin
            if (flush_done) begin
                chk(exp_done > 0, "flush_done_expected", 1, exp_done);
                if (exp_done > 0) exp_done--;
                mbusy = 0;
                done_seen = 1;
                done_fsz = fq.size();
            end
            chk_eq("busy", busy, mbusy);
            chk(!(fifo_rd_en && fifo_empty), "rd_en_on_empty", fifo_rd_en, 0);
            if (mbusy) chk_eq("rd_en_while_busy", fifo_rd_en, 0);
            if (hold) begin
                chk_eq("hold_valid", out_valid, 1);
                chk_eq("hold_data", out_data, hold_d);
                chk_eq("hold_keep", out_keep, hold_k);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_beat", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("beat_data", out_data, e.d);
                    chk_eq("beat_keep", out_keep, e.k);
                end
                got_q.push_back('{d: out_data, k: out_keep});
            end
            hold = out_valid && !out_ready;
            hold_d = out_data;
            hold_k = out_keep;
            popping = fifo_rd_en && !fifo_empty;
            if (popping) begin
                acc.push_back(fq[0]);
                if (acc.size() == R) begin
                    exp_q.push_back(pack_acc());
                    acc.delete();
                end
            end
            if (flush && !mbusy) begin
                mbusy = 1;
                exp_done++;
                if (acc.size() > 0) begin
                    exp_q.push_back(pack_acc());
                    acc.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        if (popping) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_sync_n = 1'b0;
        flush = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        cycle();
        acc.delete();
        exp_q.delete();
        mbusy = 0;
        exp_done = 0;
        hold = 0;
        rst_sync_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_out_data", out_data, 0);
        chk_eq("rst_out_keep", out_keep, 0);
        chk_eq("rst_flush_done", flush_done, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_rd_en", fifo_rd_en, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || fq.size() > 0) && c < budget) begin
            cycle();
            c++;
        end
        chk(exp_q.size() == 0 && fq.size() == 0, "drain_timeout",
            exp_q.size(), 0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done_seen && c < budget) begin
            cycle();
            c++;
        end
        chk(done_seen, "flush_done_timeout", done_seen, 1);
    endtask

    initial begin
        int g;
        int n;
        do_reset();

        // Plain stream
        out_ready = 1'b1;
        g = got_q.size();
        for (int i = 1; i <= 8; i++) push(8'(i));
        run(2);
        drain(60);
        run(3);
        chk(got_q.size() == g + 2, "stream_count", got_q.size() - g, 2);
        if (got_q.size() >= g + 2) begin
            chk_eq("stream_b0", got_q[g].d, 32'h04030201);
            chk_eq("stream_k0", got_q[g].k, 4'hF);
            chk_eq("stream_b1", got_q[g+1].d, 32'h08070605);
        end

        // Backpressure
        out_ready = 1'b0;
        g = got_q.size();
        for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
        run(30);
        chk_eq("bp_left_in_fifo", fq.size(), 4);
        chk_eq("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        drain(80);
        run(3);
        chk(got_q.size() == g + 3, "bp_count", got_q.size() - g, 3);
        if (got_q.size() >= g + 3) begin
            chk_eq("bp_b0", got_q[g].d, 32'h13121110);
            chk_eq("bp_b1", got_q[g+1].d, 32'h17161514);
            chk_eq("bp_b2", got_q[g+2].d, 32'h1B1A1918);
        end

        // Flush with a partial beat
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        run(6);
        done_seen = 0;
        pulse_flush();
        wait_done(20);
        run(3);
        chk_eq("fp_data", got_q[$].d, 32'h00CCBBAA);
        chk_eq("fp_keep", got_q[$].k, 4'b0111);
        chk_eq("fp_busy_after", busy, 0);

        // Flush with nothing packed
        g = got_q.size();
        done_seen = 0;
        pulse_flush();
        n = 0;
        while (!done_seen && n < 10) begin
            cycle();
            n++;
        end
        chk(done_seen && n <= 2, "fe_latency", n, 2);
        run(3);
        chk_eq("fe_no_beat", got_q.size(), g);

        // Flush racing the second pop
        push(8'h31);
        push(8'h32);
        push(8'h33);
        cycle();
        done_seen = 0;
        pulse_flush();
        wait_done(20);
        chk_eq("race_third_kept", done_fsz, 1);
        run(3);
        chk_eq("race_data", got_q[$].d, 32'h00003231);
        chk_eq("race_keep", got_q[$].k, 4'b0011);

        // Reset with two words packed
        push(8'h41);
        run(4);
        do_reset();
        out_ready = 1'b1;
        g = got_q.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        drain(40);
        run(3);
        chk(got_q.size() == g + 1, "rst_beat_count", got_q.size() - g, 1);
        chk_eq("rst_beat_data", got_q[$].d, 32'h44332211);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0 && fq.size() < 16)
                push(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            cycle();
            flush = 1'b0;
        end
        out_ready = 1'b1;
        n = 0;
        while ((fq.size() > 0 || mbusy) && n < 200) begin
            cycle();
            n++;
        end
        run(3);
        done_seen = 0;
        pulse_flush();
        wait_done(20);
        drain(40);
        run(4);
        chk_eq("final_exp_empty", exp_q.size(), 0);
        chk_eq("final_acc_empty", acc.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
